k12a_sequencer: RTL and testbench

Registered control sequencer for the next-generation K12A core. It owns the CPU state register and replaces the fixed three-cycle fetch with a parametrised fetch length (INST_BYTES) and a memory wait-state handshake with timeout. It also adds prioritised vectored interrupts and sticky bus-error reporting. The existing combinational strobe decoder consumes `state`, `fetch_index`, `skip_taken` and `mem_stall` to drive the datapath.

---
 rtl/k12a_sequencer.sv | 167 ++++++++++++++++
 tb/tb_k12a_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k12a_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : k12a_sequencer
// Purpose  : K12A control sequencer with variable-length fetch, wait-state
//            timeout, vectored interrupts and a sticky bus-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module k12a_sequencer #(
    parameter int          INST_WIDTH      = 16,
    parameter int          MEM_TIMEOUT     = 15,
    parameter int          NUM_IRQ         = 4,
    parameter logic [15:0] IRQ_VECTOR_BASE = 16'hFF00
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INST_WIDTH-1:0] inst,
    input  logic                  skip,
    input  logic                  wake,
    input  logic                  mem_ready,
    input  logic [NUM_IRQ-1:0]    irq,
    input  logic                  irq_enable,
    output logic [2:0]            state,
    output logic [2:0]            fetch_index,
    output logic                  skip_taken,
    output logic                  mem_stall,
    output logic                  exec_commit,
    output logic [NUM_IRQ-1:0]    irq_ack,
    output logic [15:0]           irq_vector,
    output logic                  bus_error,
    output logic                  halted
);

    localparam int         c_inst_bytes = INST_WIDTH / 8;
    localparam logic [2:0] c_last_index = 3'(c_inst_bytes - 1);
    localparam logic [7:0] c_timeout    = 8'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_FETCH_END = 3'd1,
        S_EXEC      = 3'd2,
        S_POP       = 3'd3,
        S_RJMP      = 3'd4,
        S_HALT      = 3'd5,
        S_IRQ       = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    state_t              r_state, w_state_next, w_boundary_state;
    logic [2:0]          r_fetch_index, w_fetch_index_next;
    logic [7:0]          r_wait_cnt, w_wait_cnt_next, w_wait_inc;
    logic                r_bus_error;
    logic [NUM_IRQ-1:0]  r_irq_ack, w_irq_ack_next, w_irq_onehot;
    logic [15:0]         r_irq_vector, w_irq_vector_next, w_irq_vector_sel;
    logic [2:0]          w_irq_sel;
    logic [3:0]          w_op;
    logic                w_mov, w_mode, w_mem_op, w_irq_pending;
    logic                w_stalled, w_commit;
    logic                w_unused_inst;

    assign w_op          = inst[INST_WIDTH-1 -: 4];
    assign w_mov         = inst[INST_WIDTH-5];
    assign w_mode        = inst[INST_WIDTH-6];
    assign w_unused_inst = ^inst[INST_WIDTH-7:0];
    // Memory ops are 2, 3, 6, 7: bit 3 clear and bit 1 set.
    assign w_mem_op      = !w_mov && !w_op[3] && w_op[1];
    assign w_irq_pending = irq_enable && (|irq);
    assign w_wait_inc    = r_wait_cnt + 8'd1;

    // Lowest-index request wins: scan downward so the last hit is the lowest.
    always_comb begin
        w_irq_sel    = 3'd0;
        w_irq_onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) begin
                w_irq_sel       = 3'(i);
                w_irq_onehot    = '0;
                w_irq_onehot[i] = 1'b1;
            end
        end
    end

    assign w_irq_vector_sel = IRQ_VECTOR_BASE + {11'd0, w_irq_sel, 2'b00};
    assign w_boundary_state = w_irq_pending ? S_IRQ : S_FETCH;

    always_comb begin
        w_state_next       = r_state;
        w_fetch_index_next = r_fetch_index;
        w_stalled          = 1'b0;
        w_commit           = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (!mem_ready) begin
                    w_stalled = 1'b1;
                end else if (r_fetch_index == c_last_index) begin
                    w_state_next = S_FETCH_END;
                end else begin
                    w_fetch_index_next = r_fetch_index + 3'd1;
                end
            end
            S_FETCH_END: w_state_next = S_EXEC;
            S_EXEC: begin
                if (w_mem_op && !mem_ready) begin
                    w_stalled = 1'b1;
                end else begin
                    w_commit = 1'b1;
                    if (w_op == 4'h2 && w_mode)            w_state_next = S_POP;
                    else if (w_op == 4'hC || w_op == 4'hD) w_state_next = S_RJMP;
                    else if (w_op == 4'hF)                 w_state_next = S_HALT;
                    else                                   w_state_next = w_boundary_state;
                end
            end
            S_POP, S_RJMP: w_state_next = w_boundary_state;
            S_HALT: begin
                if (w_irq_pending) w_state_next = S_IRQ;
                else if (wake)     w_state_next = S_FETCH;
            end
            S_IRQ:   w_state_next = S_FETCH;
            S_ERROR: w_state_next = S_ERROR;
            default: w_state_next = S_ERROR;
        endcase

        w_wait_cnt_next = '0;
        if (w_stalled) begin
            w_wait_cnt_next = w_wait_inc;
            if (w_wait_inc == c_timeout) w_state_next = S_ERROR;
        end
        if (w_state_next != r_state) w_wait_cnt_next = '0;
        if (w_state_next != S_FETCH) w_fetch_index_next = '0;

        w_irq_ack_next    = '0;
        w_irq_vector_next = r_irq_vector;
        if (w_state_next == S_IRQ) begin
            w_irq_ack_next    = w_irq_onehot;
            w_irq_vector_next = w_irq_vector_sel;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_fetch_index <= '0;
            r_wait_cnt    <= '0;
            r_bus_error   <= 1'b0;
            r_irq_ack     <= '0;
            r_irq_vector  <= '0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_index <= w_fetch_index_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_bus_error   <= r_bus_error || (w_state_next == S_ERROR);
            r_irq_ack     <= w_irq_ack_next;
            r_irq_vector  <= w_irq_vector_next;
        end
    end

    assign state       = r_state;
    assign fetch_index = r_fetch_index;
    assign skip_taken  = (r_state == S_FETCH) && (r_fetch_index == 3'd0) && skip;
    assign mem_stall   = w_stalled;
    assign exec_commit = w_commit;
    assign irq_ack     = r_irq_ack;
    assign irq_vector  = r_irq_vector;
    assign bus_error   = r_bus_error;
    assign halted      = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_k12a_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_k12a_sequencer
// Purpose  : Directed and randomized checking of two k12a_sequencer instances
//            against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_k12a_sequencer;

    localparam int ST_FETCH = 0, ST_FEND = 1, ST_EXEC = 2, ST_POP = 3;
    localparam int ST_RJMP = 4, ST_HALT = 5, ST_IRQ = 6, ST_ERR = 7;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        skip = 1'b0, wake = 1'b0, mem_ready = 1'b1, irq_enable = 1'b0;
    logic [15:0] inst_a = 16'h0800;
    logic [23:0] inst_b = 24'h080000;
    logic [3:0]  irq_a = '0;
    logic [2:0]  irq_b = '0;

    logic [2:0]  state_a, fetch_index_a, state_b, fetch_index_b;
    logic        skip_taken_a, mem_stall_a, exec_commit_a, bus_error_a, halted_a;
    logic        skip_taken_b, mem_stall_b, exec_commit_b, bus_error_b, halted_b;
    logic [3:0]  irq_ack_a;
    logic [2:0]  irq_ack_b;
    logic [15:0] irq_vector_a, irq_vector_b;

    int n_pass = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    k12a_sequencer #(.INST_WIDTH(16), .MEM_TIMEOUT(15), .NUM_IRQ(4), .IRQ_VECTOR_BASE(16'hFF00)) dut_a (
        .clock(clock), .reset(reset), .inst(inst_a), .skip(skip), .wake(wake),
        .mem_ready(mem_ready), .irq(irq_a), .irq_enable(irq_enable),
        .state(state_a), .fetch_index(fetch_index_a), .skip_taken(skip_taken_a),
        .mem_stall(mem_stall_a), .exec_commit(exec_commit_a), .irq_ack(irq_ack_a),
        .irq_vector(irq_vector_a), .bus_error(bus_error_a), .halted(halted_a));

    k12a_sequencer #(.INST_WIDTH(24), .MEM_TIMEOUT(3), .NUM_IRQ(3), .IRQ_VECTOR_BASE(16'hFFF8)) dut_b (
        .clock(clock), .reset(reset), .inst(inst_b), .skip(skip), .wake(wake),
        .mem_ready(mem_ready), .irq(irq_b), .irq_enable(irq_enable),
        .state(state_b), .fetch_index(fetch_index_b), .skip_taken(skip_taken_b),
        .mem_stall(mem_stall_b), .exec_commit(exec_commit_b), .irq_ack(irq_ack_b),
        .irq_vector(irq_vector_b), .bus_error(bus_error_b), .halted(halted_b));

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int st;
        int idx;
        int waits;
        int ack;
        int vec;
    } mdl_t;

    function automatic int op_of(input logic [31:0] ins, input int w);
        return int'((ins >> (w - 4)) & 32'hF);
    endfunction

    function automatic bit is_mem(input logic [31:0] ins, input int w);
        int op = op_of(ins, w);
        return !ins[w-5] && (op == 2 || op == 3 || op == 6 || op == 7);
    endfunction

    function automatic mdl_t boundary(input mdl_t m, input bit en, input int irqv, input int base);
        mdl_t n = m;
        n.st = ST_FETCH;
        if (en && irqv != 0) begin
            int k = 0;
            while (((irqv >> k) & 1) == 0) k++;
            n.st  = ST_IRQ;
            n.ack = 1 << k;
            n.vec = (base + 4 * k) & 16'hFFFF;
        end
        return n;
    endfunction

    function automatic mdl_t step(input mdl_t m, input logic [31:0] ins, input int w, input bit rdy,
                                  input bit en, input int irqv, input bit wk, input int tmo, input int base);
        mdl_t n = m;
        int op = op_of(ins, w);
        bit waiting = (m.st == ST_FETCH || (m.st == ST_EXEC && is_mem(ins, w))) && !rdy;
        n.ack = 0;
        if (waiting) begin
            n.waits = m.waits + 1;
            if (n.waits >= tmo) begin n.st = ST_ERR; n.waits = 0; n.idx = 0; end
        end else begin
            n.waits = 0;
            case (m.st)
                ST_FETCH: if (m.idx == w / 8 - 1) begin n.st = ST_FEND; n.idx = 0; end
                          else n.idx = m.idx + 1;
                ST_FEND:  n.st = ST_EXEC;
                ST_EXEC: begin
                    if (op == 2 && ins[w-6])     n.st = ST_POP;
                    else if (op == 12 || op == 13) n.st = ST_RJMP;
                    else if (op == 15)             n.st = ST_HALT;
                    else                           n = boundary(n, en, irqv, base);
                end
                ST_POP, ST_RJMP: n = boundary(n, en, irqv, base);
                ST_HALT: begin
                    if (en && irqv != 0) n = boundary(n, en, irqv, base);
                    else if (wk)         n.st = ST_FETCH;
                end
                ST_IRQ:  n.st = ST_FETCH;
                default: n.st = ST_ERR;
            endcase
        end
        return n;
    endfunction

    task automatic cmp_dut(input string tag, input mdl_t m, input logic [31:0] ins, input int w,
                           input int a_st, input int a_idx, input int a_skp, input int a_stl,
                           input int a_cmt, input int a_ack, input int a_vec, input int a_berr,
                           input int a_hlt);
        bit access = (m.st == ST_FETCH) || (m.st == ST_EXEC && is_mem(ins, w));
        check({tag, "_state"}, a_st, m.st);
        check({tag, "_fetch_index"}, a_idx, m.idx);
        check({tag, "_skip_taken"}, a_skp, int'(m.st == ST_FETCH && m.idx == 0 && skip));
        check({tag, "_mem_stall"}, a_stl, int'(access && !mem_ready));
        check({tag, "_exec_commit"}, a_cmt, int'(m.st == ST_EXEC && !(is_mem(ins, w) && !mem_ready)));
        check({tag, "_irq_ack"}, a_ack, (m.st == ST_IRQ) ? m.ack : 0);
        if (m.st == ST_IRQ) check({tag, "_irq_vector"}, a_vec, m.vec);
        check({tag, "_bus_error"}, a_berr, int'(m.st == ST_ERR));
        check({tag, "_halted"}, a_hlt, int'(m.st == ST_HALT));
    endtask

    mdl_t ma, mb;

    always @(negedge clock) begin
        if (reset) begin
            ma = '{0, 0, 0, 0, 0};
            mb = '{0, 0, 0, 0, 0};
        end
        cmp_dut("A", ma, {16'd0, inst_a}, 16, state_a, fetch_index_a, skip_taken_a, mem_stall_a,
                exec_commit_a, irq_ack_a, irq_vector_a, bus_error_a, halted_a);
        cmp_dut("B", mb, {8'd0, inst_b}, 24, state_b, fetch_index_b, skip_taken_b, mem_stall_b,
                exec_commit_b, irq_ack_b, irq_vector_b, bus_error_b, halted_b);
        if (!reset) begin
            ma = step(ma, {16'd0, inst_a}, 16, mem_ready, irq_enable, irq_a, wake, 15, 16'hFF00);
            mb = step(mb, {8'd0, inst_b}, 24, mem_ready, irq_enable, irq_b, wake, 3, 16'hFFF8);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        next_cycle();
        reset = 1'b0;
    endtask

    // Returns at the negedge of the cycle in which the state was reached.
    task automatic wait_for(input bit use_b, input int s, input int bound, input string name);
        bit found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clock);
            if (int'(use_b ? state_b : state_a) == s) found = 1'b1;
            else next_cycle();
        end
        check(name, int'(found), 1);
    endtask

    int exp_sa[5]  = '{0, 0, 1, 2, 0};
    int exp_ia[5]  = '{0, 1, 0, 0, 0};
    int exp_ca[5]  = '{0, 0, 0, 1, 0};
    int exp_ska[5] = '{1, 0, 0, 0, 0};
    int exp_sb[5]  = '{0, 0, 0, 1, 2};
    int exp_ib[5]  = '{0, 1, 2, 0, 0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_run = 0;

        // Reset state and basic 16/24-bit fetch timing with skip.
        @(negedge clock);
        check("reset_state", state_a, 0);
        check("reset_bus_error", bus_error_a, 0);
        check("reset_irq_ack", irq_ack_a, 0);
        next_cycle();
        reset = 1'b0;
        skip  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check($sformatf("mov_state_c%0d", c + 1), state_a, exp_sa[c]);
            check($sformatf("mov_index_c%0d", c + 1), fetch_index_a, exp_ia[c]);
            check($sformatf("mov_commit_c%0d", c + 1), exec_commit_a, exp_ca[c]);
            check($sformatf("skip_taken_c%0d", c + 1), skip_taken_a, exp_ska[c]);
            check($sformatf("w24_state_c%0d", c + 1), state_b, exp_sb[c]);
            check($sformatf("w24_index_c%0d", c + 1), fetch_index_b, exp_ib[c]);
            next_cycle();
            if (c == 1) skip = 1'b0;
        end

        // Load with three wait states in EXEC.
        inst_a = 16'h2000;
        wait_for(1'b0, ST_FEND, 10, "wait_ld_fetch_end");
        next_cycle();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("ld_state", state_a, ST_EXEC);
            check("ld_stall", mem_stall_a, 1);
            check("ld_commit_early", exec_commit_a, 0);
            next_cycle();
        end
        mem_ready = 1'b1;
        @(negedge clock);
        check("ld_commit", exec_commit_a, 1);
        check("ld_stall_done", mem_stall_a, 0);
        next_cycle();

        // Fetch timeout: 15 stalled cycles then ERROR.
        mem_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            check("tmo_state_fetch", state_a, ST_FETCH);
            check("tmo_stall", mem_stall_a, 1);
            if (k == 15) check("tmo_no_error_yet", bus_error_a, 0);
            next_cycle();
        end
        @(negedge clock);
        check("tmo_state_error", state_a, ST_ERR);
        check("tmo_bus_error", bus_error_a, 1);
        check("tmo_b_state_error", state_b, ST_ERR);
        check("tmo_b_bus_error", bus_error_b, 1);
        next_cycle();
        mem_ready = 1'b1;
        @(negedge clock);
        check("error_terminal", state_a, ST_ERR);
        next_cycle();

        // Ready on the last permitted cycle: no error.
        mem_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            next_cycle();
        end
        mem_ready = 1'b1;
        @(negedge clock);
        check("edge_stall", mem_stall_a, 0);
        check("edge_state", state_a, ST_FETCH);
        next_cycle();
        @(negedge clock);
        check("edge_index", fetch_index_a, 1);
        check("edge_bus_error", bus_error_a, 0);
        next_cycle();

        // HALT with irq and wake together: irq wins.
        inst_a = 16'hF000;
        do_reset();
        wait_for(1'b0, ST_HALT, 10, "wait_halt");
        next_cycle();
        irq_a = 4'b0110;
        irq_enable = 1'b1;
        wake = 1'b1;
        @(negedge clock);
        check("halt_halted", halted_a, 1);
        next_cycle();
        irq_a = '0;
        wake = 1'b0;
        irq_enable = 1'b0;
        @(negedge clock);
        check("halt_irq_state", state_a, ST_IRQ);
        check("halt_irq_ack", irq_ack_a, 4'b0010);
        check("halt_irq_vector", irq_vector_a, 16'hFF04);
        next_cycle();
        @(negedge clock);
        check("post_irq_state", state_a, ST_FETCH);
        check("post_irq_ack", irq_ack_a, 0);
        next_cycle();

        // RJMP with interrupts disabled.
        inst_a = 16'hC000;
        irq_a = 4'b0001;
        do_reset();
        wait_for(1'b0, ST_EXEC, 10, "wait_rjmp_exec");
        next_cycle();
        @(negedge clock);
        check("rjmp_state", state_a, ST_RJMP);
        check("rjmp_ack", irq_ack_a, 0);
        next_cycle();
        @(negedge clock);
        check("rjmp_fetch", state_a, ST_FETCH);
        check("rjmp_ack_after", irq_ack_a, 0);
        next_cycle();

        // Vector address wraps at 16 bits on the 24-bit instance.
        irq_a = '0;
        irq_b = 3'b100;
        irq_enable = 1'b1;
        do_reset();
        wait_for(1'b1, ST_IRQ, 12, "wait_irq_b");
        check("wrap_ack", irq_ack_b, 3'b100);
        check("wrap_vector", irq_vector_b, 16'h0000);
        next_cycle();
        irq_b = '0;
        irq_enable = 1'b0;

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            if (stall_run > 0) begin
                mem_ready = 1'b0;
                stall_run--;
            end else if ($urandom_range(0, 59) == 0) begin
                stall_run = $urandom_range(1, 20);
                mem_ready = 1'b0;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            reset      = ($urandom_range(0, 149) == 0);
            skip       = $urandom_range(0, 1) != 0;
            wake       = ($urandom_range(0, 3) == 0);
            irq_enable = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 7) == 0) begin
                irq_a = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'd0;
                irq_b = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            end
            inst_a = 16'($urandom);
            inst_b = 24'($urandom);
            next_cycle();
        end
        reset = 1'b0;
        @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
